prog_core_param: RTL and testbench

Parametrised successor to the 4-bit programmable control core. It holds a loadable program memory, a small register file, an accumulator with Z/C flags and several output ports. It executes one instruction per clock, and adds conditional branches, a halt state and multiple output channels. An optional hardware call/return stack is compiled in with a macro. It sits between the host loader, which drives `mem_write`/`instr`/`portin`, and the downstream port consumers.

---
 rtl/prog_core_param.sv | 252 +++++++++++++++++++++++++
 tb/tb_prog_core_param.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_core_param.sv
// prog_core_param
// Parametrised programmable control core. It holds a loadable program memory,
// a small register file and an accumulator with Z/C flags, and it drives NOUT
// registered output channels. The core executes one instruction per clock,
// supports conditional branches, and stops on HALT.
//
// Optional feature macro: PROG_CALL_EN
//   When defined, a STACK_DEPTH-entry hardware call/return stack is built for
//   CALL (1110) and RET (1111). When undefined, both opcodes act as NOP and
//   stack_err is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   PC_reset_n asynchronous active-low reset
//   restart    synchronous restart: clears pc, write pointer, halt and stack;
//              keeps memory, registers, ACC and output channels
//   mem_write  load mode: stores {instr, portin} at the write pointer; the
//              core does not execute while this is high
//   instr      opcode to load
//   portin     operand during load, data source for IN during run
//   portout    NOUT registered channels, channel k at [k*DW +: DW]
//   pc         current program counter
//   halted     core stopped by HALT
//   prog_full  write pointer has reached DEPTH
//   stack_err  sticky stack overflow/underflow flag
module prog_core_param #(
  parameter int DW          = 4,
  parameter int DEPTH       = 16,
  parameter int NOUT        = 2,
  parameter int NREG        = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     PC_reset_n,
  input  logic                     restart,
  input  logic                     mem_write,
  input  logic [3:0]               instr,
  input  logic [DW-1:0]            portin,
  output logic [NOUT*DW-1:0]       portout,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     halted,
  output logic                     prog_full,
  output logic                     stack_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int RI = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_ST, OP_LD, OP_IN, OP_HALT,
    OP_OUT, OP_JMP, OP_JZ, OP_JC, OP_ADDR, OP_AND, OP_CALL, OP_RET
  } opcode_e;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e             r_state, w_stateNext;
  logic [DW+3:0]      r_mem [DEPTH];
  logic [AW:0]        r_wptr;
  logic [AW-1:0]      r_pc, w_pcNext, w_pcInc, w_target;
  logic [DW-1:0]      r_acc;
  logic               r_z, r_c;
  logic [DW-1:0]      r_regs [NREG];
  logic [NOUT*DW-1:0] r_portout;

  logic [DW+3:0]      w_word;
  opcode_e            w_opcode;
  logic [DW-1:0]      w_operand, w_regData, w_and;
  logic [RI-1:0]      w_regIdx;
  logic [DW:0]        w_sum, w_diff, w_sumReg;
  logic               w_exec, w_full;

  assign w_word    = r_mem[r_pc];
  assign w_opcode  = opcode_e'(w_word[DW+3:DW]);
  assign w_operand = w_word[DW-1:0];
  assign w_regIdx  = w_operand[RI-1:0];
  assign w_target  = w_operand[AW-1:0];
  assign w_regData = r_regs[w_regIdx];

  // Bit DW of each result is the carry (ADD/ADDR) or the borrow (SUB).
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_operand};
  assign w_diff   = {1'b0, r_acc} - {1'b0, w_operand};
  assign w_sumReg = {1'b0, r_acc} + {1'b0, w_regData};
  assign w_and    = r_acc & w_operand;

  assign w_full  = (r_wptr == (AW+1)'(DEPTH));
  assign w_pcInc = (r_pc == AW'(DEPTH-1)) ? '0 : r_pc + AW'(1);
  assign w_exec  = !restart && !mem_write && (r_state == ST_RUN);

`ifdef PROG_CALL_EN
  localparam int SPW = $clog2(STACK_DEPTH+1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [AW-1:0]  r_stack [STACK_DEPTH];
  logic [SPW-1:0] r_sp, w_spDec;
  logic           r_stackErr;
  logic           w_push, w_pop, w_stackErrSet, w_stackFull, w_stackEmpty;
  logic [AW-1:0]  w_retAddr;

  assign w_spDec      = r_sp - SPW'(1);
  assign w_stackFull  = (r_sp == SPW'(STACK_DEPTH));
  assign w_stackEmpty = (r_sp == '0);
  assign w_retAddr    = r_stack[w_spDec[SIW-1:0]];
`endif

  // Control: next run/halt state and next pc. restart outranks everything,
  // and load mode or halt simply holds pc where it is.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
`ifdef PROG_CALL_EN
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_stackErrSet = 1'b0;
`endif
    if (restart) begin
      w_stateNext = ST_RUN;
      w_pcNext    = '0;
    end else if (w_exec) begin
      w_pcNext = w_pcInc;
      case (w_opcode)
        OP_HALT: begin
          w_stateNext = ST_HALT;
          w_pcNext    = r_pc;
        end
        OP_JMP: w_pcNext = w_target;
        OP_JZ:  if (r_z) w_pcNext = w_target;
        OP_JC:  if (r_c) w_pcNext = w_target;
`ifdef PROG_CALL_EN
        // A full stack still takes the call; only the return address is lost.
        OP_CALL: begin
          w_pcNext = w_target;
          if (w_stackFull) w_stackErrSet = 1'b1;
          else             w_push        = 1'b1;
        end
        OP_RET: begin
          if (w_stackEmpty) begin
            w_stackErrSet = 1'b1;
          end else begin
            w_pop    = 1'b1;
            w_pcNext = w_retAddr;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge PC_reset_n) begin
    if (!PC_reset_n) begin
      r_state <= ST_RUN;
      r_pc    <= '0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
    end
  end

  // Datapath: accumulator, flags, register file and output channels.
  always_ff @(posedge clk or negedge PC_reset_n) begin
    if (!PC_reset_n) begin
      r_acc     <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_portout <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_exec) begin
      case (w_opcode)
        OP_LDI: begin
          r_acc <= w_operand;
          r_z   <= (w_operand == '0);
        end
        OP_ADD: begin
          r_acc <= w_sum[DW-1:0];
          r_c   <= w_sum[DW];
          r_z   <= (w_sum[DW-1:0] == '0);
        end
        OP_SUB: begin
          r_acc <= w_diff[DW-1:0];
          r_c   <= w_diff[DW];
          r_z   <= (w_diff[DW-1:0] == '0);
        end
        OP_ST: r_regs[w_regIdx] <= r_acc;
        OP_LD: begin
          r_acc <= w_regData;
          r_z   <= (w_regData == '0);
        end
        OP_IN: begin
          r_acc <= portin;
          r_z   <= (portin == '0);
        end
        // Operands that name no existing channel leave every channel alone.
        OP_OUT: begin
          for (int k = 0; k < NOUT; k++)
            if (w_operand == DW'(k)) r_portout[k*DW +: DW] <= r_acc;
        end
        OP_ADDR: begin
          r_acc <= w_sumReg[DW-1:0];
          r_c   <= w_sumReg[DW];
          r_z   <= (w_sumReg[DW-1:0] == '0);
        end
        OP_AND: begin
          r_acc <= w_and;
          r_z   <= (w_and == '0);
        end
        default: ;
      endcase
    end
  end

  // Write pointer stops at DEPTH so a full memory ignores further loads.
  always_ff @(posedge clk or negedge PC_reset_n) begin
    if (!PC_reset_n)                 r_wptr <= '0;
    else if (restart)                r_wptr <= '0;
    else if (mem_write && !w_full)   r_wptr <= r_wptr + (AW+1)'(1);
  end

  // Program memory has no reset so a program survives PC_reset_n.
  always_ff @(posedge clk) begin
    if (!restart && mem_write && !w_full)
      r_mem[r_wptr[AW-1:0]] <= {instr, portin};
  end

`ifdef PROG_CALL_EN
  always_ff @(posedge clk or negedge PC_reset_n) begin
    if (!PC_reset_n) begin
      r_sp       <= '0;
      r_stackErr <= 1'b0;
    end else if (restart) begin
      r_sp <= '0;
    end else begin
      if (w_push)     r_sp <= r_sp + SPW'(1);
      else if (w_pop) r_sp <= w_spDec;
      if (w_stackErrSet) r_stackErr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[SIW-1:0]] <= w_pcInc;
  end

  assign stack_err = r_stackErr;
`else
  assign stack_err = 1'b0;
`endif

  assign portout   = r_portout;
  assign pc        = r_pc;
  assign halted    = (r_state == ST_HALT);
  assign prog_full = w_full;

endmodule

// File: tb/tb_prog_core_param.sv
// tb_prog_core_param
// Self-checking bench for prog_core_param at default parameters. A table of
// hand-derived vectors covers the basic program, hand sequences cover the
// branch, loop, reset/restart, load-overflow and CALL/RET cases, and a random
// phase is compared cycle by cycle against an instruction-level model.
// Honours PROG_CALL_EN in the same way as the design.
module tb_prog_core_param;

  localparam int DW = 4, DEPTH = 16, NOUT = 2, NREG = 4, STACK_DEPTH = 4;

  logic                clk, PC_reset_n, restart, mem_write;
  logic [3:0]          instr;
  logic [DW-1:0]       portin;
  logic [NOUT*DW-1:0]  portout;
  logic [3:0]          pc;
  logic                halted, prog_full, stack_err;

  int errors = 0;
  int checks = 0;

  prog_core_param #(
    .DW(DW), .DEPTH(DEPTH), .NOUT(NOUT), .NREG(NREG), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .PC_reset_n(PC_reset_n), .restart(restart), .mem_write(mem_write),
    .instr(instr), .portin(portin), .portout(portout), .pc(pc),
    .halted(halted), .prog_full(prog_full), .stack_err(stack_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Instruction-level reference model.
  int mMem [DEPTH];
  int mAcc, mZ, mC, mPc, mHalt, mWptr, mErr;
  int mReg [NREG];
  int mPort [NOUT];
  int mStack [$];

  function automatic void modelReset();
    mAcc = 0; mZ = 0; mC = 0; mPc = 0; mHalt = 0; mWptr = 0; mErr = 0;
    for (int i = 0; i < NREG; i++) mReg[i] = 0;
    for (int i = 0; i < NOUT; i++) mPort[i] = 0;
    mStack.delete();
  endfunction

  function automatic void modelStep(input int rs, input int mw, input int ins, input int pin);
    int op, opd, npc, s;
    if (rs != 0) begin
      mPc = 0; mWptr = 0; mHalt = 0; mStack.delete();
      return;
    end
    if (mw != 0) begin
      if (mWptr < DEPTH) begin
        mMem[mWptr] = ins * 16 + pin;
        mWptr++;
      end
      return;
    end
    if (mHalt != 0) return;
    op  = mMem[mPc] / 16;
    opd = mMem[mPc] % 16;
    npc = (mPc + 1) % DEPTH;
    case (op)
      1:  begin mAcc = opd; mZ = (mAcc == 0); end
      2:  begin s = mAcc + opd; mC = (s > 15); mAcc = s % 16; mZ = (mAcc == 0); end
      3:  begin mC = (mAcc < opd); mAcc = (mAcc - opd + 16) % 16; mZ = (mAcc == 0); end
      4:  mReg[opd % NREG] = mAcc;
      5:  begin mAcc = mReg[opd % NREG]; mZ = (mAcc == 0); end
      6:  begin mAcc = pin; mZ = (mAcc == 0); end
      7:  begin mHalt = 1; npc = mPc; end
      8:  if (opd < NOUT) mPort[opd] = mAcc;
      9:  npc = opd % DEPTH;
      10: if (mZ != 0) npc = opd % DEPTH;
      11: if (mC != 0) npc = opd % DEPTH;
      12: begin s = mAcc + mReg[opd % NREG]; mC = (s > 15); mAcc = s % 16; mZ = (mAcc == 0); end
      13: begin mAcc = mAcc & opd; mZ = (mAcc == 0); end
`ifdef PROG_CALL_EN
      14: begin
        if (mStack.size() >= STACK_DEPTH) mErr = 1;
        else mStack.push_back(npc);
        npc = opd % DEPTH;
      end
      15: begin
        if (mStack.size() == 0) mErr = 1;
        else npc = mStack.pop_back();
      end
`endif
      default: ;
    endcase
    mPc = npc;
  endfunction

  task automatic applyStimulus(input logic rs, input logic mw, input logic [3:0] ins,
                               input logic [3:0] pin);
    restart   = rs;
    mem_write = mw;
    instr     = ins;
    portin    = pin;
    @(posedge clk);
    modelStep(int'(rs), int'(mw), int'(ins), int'(pin));
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name);
    logic [14:0] act, exp;
    int expPort;
    expPort = mPort[1] * 16 + mPort[0];
    act = {portout, pc, halted, prog_full, stack_err};
    exp = {8'(expPort), 4'(mPc), 1'(mHalt), 1'(mWptr == DEPTH), 1'(mErr)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got portout=%h pc=%0d halted=%b full=%b serr=%b, required portout=%h pc=%0d halted=%b full=%b serr=%b",
               name, portout, pc, halted, prog_full, stack_err,
               exp[14:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic pulseReset();
    PC_reset_n = 1'b0;
    #1;
    modelReset();
    checkVal("async reset portout", int'(portout), 0);
    checkVal("async reset pc", int'(pc), 0);
    #1;
    PC_reset_n = 1'b1;
  endtask

  task automatic loadProgram(input logic [7:0] prog [$]);
    foreach (prog[i]) applyStimulus(1'b0, 1'b1, prog[i][7:4], prog[i][3:0]);
  endtask

  task automatic runChecked(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
      checkOutput(name);
    end
  endtask

  typedef struct {
    logic       rs;
    logic       mw;
    logic [3:0] ins;
    logic [3:0] pin;
    logic [7:0] ePort;
    logic [3:0] ePc;
    logic       eHalt;
    logic       eFull;
  } vec_t;

  vec_t vecs [14];
  logic [7:0] prog [$];

  initial begin
    // Basic program LDI 3, ADD 5, OUT 0, HALT, then restart with a
    // simultaneous write that must be dropped, then a rerun.
    vecs[0]  = '{1'b0, 1'b1, 4'h1, 4'h3, 8'h00, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'h2, 4'h5, 8'h00, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'h8, 4'h0, 8'h00, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'h7, 4'h0, 8'h00, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 4'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 4'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h08, 4'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h08, 4'd3, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h08, 4'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 4'h1, 4'h9, 8'h08, 4'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h08, 4'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h08, 4'd2, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h08, 4'd3, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 4'h0, 4'h0, 8'h08, 4'd3, 1'b1, 1'b0};

    PC_reset_n = 1'b0;
    restart    = 1'b0;
    mem_write  = 1'b0;
    instr      = 4'h0;
    portin     = 4'h0;
    for (int i = 0; i < DEPTH; i++) mMem[i] = 0;
    modelReset();
    #2;
    checkVal("reset portout", int'(portout), 0);
    checkVal("reset pc", int'(pc), 0);
    checkVal("reset halted", int'(halted), 0);
    checkVal("reset prog_full", int'(prog_full), 0);
    checkVal("reset stack_err", int'(stack_err), 0);
    @(negedge clk);
    PC_reset_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rs, vecs[i].mw, vecs[i].ins, vecs[i].pin);
      checks++;
      if ({portout, pc, halted, prog_full} !== {vecs[i].ePort, vecs[i].ePc, vecs[i].eHalt, vecs[i].eFull}) begin
        errors++;
        $display("[TB] FAIL vector %0d: got portout=%h pc=%0d halted=%b full=%b, required portout=%h pc=%0d halted=%b full=%b",
                 i, portout, pc, halted, prog_full,
                 vecs[i].ePort, vecs[i].ePc, vecs[i].eHalt, vecs[i].eFull);
      end
    end

    // Carry-taken branch: LDI 15, ADD 1, JC 5, OUT 0, HALT, LDI 9, OUT 1, HALT.
    pulseReset();
    prog = '{8'h1F, 8'h21, 8'hB5, 8'h80, 8'h70, 8'h19, 8'h81, 8'h70};
    loadProgram(prog);
    runChecked("branch run", 7);
    checkVal("branch portout", int'(portout), 8'h90);
    checkVal("branch halted", int'(halted), 1);
    checkVal("branch pc", int'(pc), 7);

    // Countdown loop: LDI 3, SUB 1, OUT 1, JZ 5, JMP 1, HALT.
    pulseReset();
    prog = '{8'h13, 8'h31, 8'h81, 8'hA5, 8'h91, 8'h70};
    loadProgram(prog);
    for (int i = 1; i <= 13; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
      checkOutput("loop run");
      if (i == 3)  checkVal("loop ch1 first", int'(portout[7:4]), 2);
      if (i == 7)  checkVal("loop ch1 second", int'(portout[7:4]), 1);
      if (i == 11) checkVal("loop ch1 third", int'(portout[7:4]), 0);
    end
    checkVal("loop halted", int'(halted), 1);
    checkVal("loop pc", int'(pc), 5);

    // Reset mid-loop, then restart from the retained program.
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    runChecked("loop rerun before reset", 6);
    checkVal("loop mid portout", int'(portout), 8'h20);
    pulseReset();
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    checkOutput("restart after reset");
    runChecked("loop rerun", 13);
    checkVal("rerun ch1", int'(portout[7:4]), 0);
    checkVal("rerun halted", int'(halted), 1);
    checkVal("rerun pc", int'(pc), 5);

    // Load overflow: the 17th write must not touch word 0.
    pulseReset();
    for (int i = 0; i < 17; i++) begin
      logic [7:0] w;
      w = (i == 0) ? 8'h15 : (i == 1) ? 8'h80 : (i == 2) ? 8'h70 : (i == 16) ? 8'h19 : 8'h00;
      applyStimulus(1'b0, 1'b1, w[7:4], w[3:0]);
      if (i == 14) checkVal("prog_full after 15 writes", int'(prog_full), 0);
      if (i == 15) checkVal("prog_full after 16 writes", int'(prog_full), 1);
      if (i == 16) checkVal("prog_full after 17 writes", int'(prog_full), 1);
    end
    runChecked("overflow run", 4);
    checkVal("overflow ch0", int'(portout[3:0]), 5);
    checkVal("overflow halted", int'(halted), 1);

    // CALL/RET: LDI 6, CALL 5, HALT, NOP, NOP, OUT 0, RET, HALT.
    pulseReset();
    prog = '{8'h16, 8'hE5, 8'h70, 8'h00, 8'h00, 8'h80, 8'hF0, 8'h70};
    loadProgram(prog);
    runChecked("call run", 6);
`ifdef PROG_CALL_EN
    checkVal("call ch0", int'(portout[3:0]), 6);
`else
    checkVal("call ch0", int'(portout[3:0]), 0);
`endif
    checkVal("call pc", int'(pc), 2);
    checkVal("call halted", int'(halted), 1);
    checkVal("call stack_err", int'(stack_err), 0);

`ifdef PROG_CALL_EN
    // Five nested calls overflow a four-entry stack.
    pulseReset();
    prog = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'h70};
    loadProgram(prog);
    runChecked("nested call run", 6);
    checkVal("nested stack_err", int'(stack_err), 1);
`endif

    // Random programs and control traffic against the model.
    for (int blk = 0; blk < 6; blk++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      checkOutput("random restart");
      for (int i = 0; i < DEPTH; i++) begin
        applyStimulus(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        checkOutput("random load");
      end
      for (int i = 0; i < 120; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 3)
          applyStimulus(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        else if (r < 8)
          applyStimulus(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        else
          applyStimulus(1'b0, 1'b0, 4'h0, 4'($urandom_range(0, 15)));
        checkOutput("random run");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
